debouncer_bank: RTL
===================

# debouncer_bank

Parametrised multi-channel debouncer with edge-pulse outputs and glitch abort. It is the successor to the single-channel debouncer. Each of `CHANNELS` independent inputs (buttons, switches, external strobes) is filtered by its own small state machine and counter. A channel's output changes only after the new level has been held for `BOUNCE_TICKS` consecutive cycles. The block sits between board-level pins and the synchronous control logic, which consumes either the filtered levels or the one-cycle edge pulses.

## Interface
- `CHANNELS`, default 4: number of independent channels; must be ≥ 1.
- `BOUNCE_TICKS`, default 10: consecutive cycles the new level must persist after first detection; must be ≥ 1.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `bouncy_in`  input  CHANNELS  raw inputs; bit i belongs to channel i.
- `debounced_out`  output  CHANNELS  filtered level per channel, registered.
- `rise`  output  CHANNELS  one-cycle pulse when `debounced_out[i]` goes 0→1.
- `fall`  output  CHANNELS  one-cycle pulse when `debounced_out[i]` goes 1→0.
- `any_change`  output  1  OR-reduction of `rise | fall`, combinational from registered values.

## Operation
- Per-channel FSM with four states: STABLE0, PEND1, STABLE1, PEND0.
- Per-channel counter, width `$clog2(BOUNCE_TICKS+1)`.
- Counter is held at 0 in STABLE states.
- `s[i]` is the sampled input: `bouncy_in[i]` directly, or the synchroniser output (see Configuration).
- STABLE0:
  - `s=1` → PEND1, counter 0.
  - Otherwise stay.
- PEND1:
  - `s=0` → STABLE0 (abort), counter 0.
  - `s=1` and counter == `BOUNCE_TICKS-1` → STABLE1.
  - Otherwise counter +1.
- STABLE1 / PEND0: mirror of the above with levels inverted.
- Output levels:
  - `debounced_out[i]` = 0 in STABLE0 and PEND1.
  - `debounced_out[i]` = 1 in STABLE1 and PEND0.
  - A held level is therefore never disturbed by a glitch shorter than the filter window.
- Edge pulses:
  - `rise[i]` is registered and asserted for exactly the cycle after the PEND1→STABLE1 transition edge, i.e. the first cycle `debounced_out[i]` reads 1.
  - `fall[i]` is the same for PEND0→STABLE0.
  - `rise[i]` and `fall[i]` are never both 1.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- The counter never exceeds `BOUNCE_TICKS-1`; no wrap-around is possible.

## Timing
- Reset (`rst`=0), asynchronous:
  - All FSMs to STABLE0; counters 0.
  - `debounced_out`, `rise`, `fall`, `any_change` all 0.
  - Synchroniser flops cleared.
- Reset asserted mid-PEND discards the pending transition; no pulse is emitted.
- Reset release is sampled at the next rising edge.
- Latency (no synchroniser):
  - Let edge e0 be the first edge that samples the new level.
  - `debounced_out` and the edge pulse update after edge e0+`BOUNCE_TICKS`.
  - Requires `BOUNCE_TICKS+1` consecutive matching samples (edges e0 … e0+`BOUNCE_TICKS`).
- Any single opposite sample in that window returns the FSM to the prior STABLE state. The window restarts at the next matching sample.
- `BOUNCE_TICKS`=1: two consecutive matching samples suffice.

## Configuration
- `DEBOUNCER_SYNC_EN`:
  - Defined: each channel gets a two-flop synchroniser (async-reset to 0) ahead of the FSM, and `s` is the second flop. All latencies grow by exactly 2 cycles. Use this for asynchronous pin inputs.
  - Undefined: `s = bouncy_in` directly. The caller guarantees `bouncy_in` is synchronous to `clk`.

## Test plan
- Reset: hold `rst`=0 with `bouncy_in`=4'hF, then release → all outputs 0 at release, and channels begin PEND1 on the first edge.
- Clean step, `CHANNELS`=4, `BOUNCE_TICKS`=10, ch0 0→1 held → `debounced_out[0]`=1 after edge e0+10 (e0+12 with `DEBOUNCER_SYNC_EN`), `rise[0]` high exactly 1 cycle, `any_change`=1 that cycle.
- Glitch abort: ch1 high for 5 cycles, low 1 cycle, then high → no output change until 11 consecutive high samples after the low sample.
- Bounce on release: ch2 stable high, toggles 1-0-1-0 at 1-cycle spacing then settles low → `debounced_out[2]` stays 1 through the toggles, falls exactly once, single `fall[2]` pulse.
- Simultaneous: ch0 and ch3 rise on the same edge → `rise`=4'b1001 for one cycle; `fall`=0.
- Reset mid-PEND: assert `rst`=0 at counter=7 on ch0, then release with input still high → no `rise` pulse; full 11-sample window restarts.

Source files
------------

// File: rtl/debouncer_bank.sv
// debouncer_bank: per-channel FSM debouncer with registered rise/fall pulses.
// Define DEBOUNCER_SYNC_EN to put a two-flop synchroniser ahead of each channel.
module debouncer_bank #(
  parameter int CHANNELS     = 4,
  parameter int BOUNCE_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] bouncy_in,
  output logic [CHANNELS-1:0] debounced_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);
  localparam int CW = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(BOUNCE_TICKS - 1);
  typedef enum logic [1:0] {STABLE0, PEND1, STABLE1, PEND0} state_t;
  logic [CHANNELS-1:0] s;
`ifdef DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bouncy_in;
      sync2 <= sync1;
    end
  assign s = sync2;
`else
  assign s = bouncy_in;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        st;
    logic [CW-1:0] cnt;
    logic          d, r, f;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        st  <= STABLE0;
        cnt <= '0;
        d   <= 1'b0;
        r   <= 1'b0;
        f   <= 1'b0;
      end else begin
        r <= 1'b0;
        f <= 1'b0;
        case (st)
          STABLE0: if (s[i]) begin
            st  <= PEND1;
            cnt <= '0;
          end
          PEND1: if (!s[i]) begin
            st  <= STABLE0;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= STABLE1;
            cnt <= '0;
            d   <= 1'b1;
            r   <= 1'b1;
          end else cnt <= cnt + 1'b1;
          STABLE1: if (!s[i]) begin
            st  <= PEND0;
            cnt <= '0;
          end
          PEND0: if (s[i]) begin
            st  <= STABLE1;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= STABLE0;
            cnt <= '0;
            d   <= 1'b0;
            f   <= 1'b1;
          end else cnt <= cnt + 1'b1;
          default: begin
            st  <= STABLE0;
            cnt <= '0;
          end
        endcase
      end
    assign debounced_out[i] = d;
    assign rise[i]          = r;
    assign fall[i]          = f;
  end
  assign any_change = |(rise | fall);
endmodule
